cpu_control_sequencer: RTL and testbench

- Multi-cycle control unit for the 4-bit-opcode accumulator CPU.
- Consumes the one-hot instruction-decoder outputs (LDA…HLT) and the accumulator Z/N flags.
- Sequences fetch, decode and execute by driving PC, MAR, IR, memory and ALU/accumulator control strobes.
- Handles memory wait states through a ready handshake with a timeout.

---
 rtl/cpu_ctrl_if.sv | 44 ++++
 rtl/cpu_control_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
// Control bundle between the instruction decoder / datapath and the sequencer.
// The master side is the sequencer: it reads decoder lines and flags, and drives strobes.
interface cpu_ctrl_if;
  logic       LDA;
  logic       STA;
  logic       ADD;
  logic       SUB;
  logic       XOR;
  logic       INC;
  logic       CLR;
  logic       JMP;
  logic       JPZ;
  logic       JPN;
  logic       HLT;
  logic       Z;
  logic       N;
  logic       MEM_RDY;
  logic       PC_INC;
  logic       PC_LD;
  logic       MAR_SEL;
  logic       MAR_LD;
  logic       IR_LD;
  logic       MEM_RD;
  logic       MEM_WR;
  logic       ACC_LD;
  logic       ACC_CLR;
  logic [2:0] ALU_OP;
  logic       HALTED;
  logic       ILLEGAL;
  logic       BUS_ERR;
  logic [2:0] STATE;

  modport master (
    input  LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT, Z, N, MEM_RDY,
    output PC_INC, PC_LD, MAR_SEL, MAR_LD, IR_LD, MEM_RD, MEM_WR,
           ACC_LD, ACC_CLR, ALU_OP, HALTED, ILLEGAL, BUS_ERR, STATE
  );

  modport slave (
    output LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT, Z, N, MEM_RDY,
    input  PC_INC, PC_LD, MAR_SEL, MAR_LD, IR_LD, MEM_RD, MEM_WR,
           ACC_LD, ACC_CLR, ALU_OP, HALTED, ILLEGAL, BUS_ERR, STATE
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU,
// with memory wait states and a sticky bus-error on access timeout.
module cpu_control_sequencer #(
  parameter int TO_CYC = 15,
  parameter int TO_W   = 8
) (
  input  logic      CLK,
  input  logic      RST,
  cpu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_F0   = 3'd0,
    S_F1   = 3'd1,
    S_DEC  = 3'd2,
    S_MEM  = 3'd3,
    S_EX   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [2:0]      ALU_PASS = 3'b000;
  localparam logic [2:0]      ALU_ADD  = 3'b001;
  localparam logic [2:0]      ALU_SUB  = 3'b010;
  localparam logic [2:0]      ALU_XOR  = 3'b011;
  localparam logic [2:0]      ALU_INC  = 3'b100;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYC - 1);

  state_t          state_r;
  state_t          next_state_s;
  logic [TO_W-1:0] tmo_r;
  logic            bus_err_r;
  logic [10:0]     dec_s;
  logic            waiting_s;
  logic            timeout_s;
  logic            dec_ok_s;
  logic            mem_op_s;
  logic            ex_op_s;

  logic            pc_inc_s;
  logic            pc_ld_s;
  logic            mar_sel_s;
  logic            mar_ld_s;
  logic            ir_ld_s;
  logic            mem_rd_s;
  logic            mem_wr_s;
  logic            acc_ld_s;
  logic            acc_clr_s;
  logic [2:0]      alu_op_s;
  logic            illegal_s;

  function automatic logic [3:0] count_ones(input logic [10:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 11; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  assign dec_s = {bus.HLT, bus.JPN, bus.JPZ, bus.JMP, bus.CLR, bus.INC,
                  bus.XOR, bus.SUB, bus.ADD, bus.STA, bus.LDA};

  assign dec_ok_s  = (count_ones(dec_s) == 4'd1);
  assign mem_op_s  = |dec_s[4:0];
  assign ex_op_s   = |dec_s[9:5];
  assign waiting_s = ((state_r == S_F1) || (state_r == S_MEM)) && !bus.MEM_RDY;
  assign timeout_s = waiting_s && (tmo_r == TO_LAST);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= S_F0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Wait-state counter: restarts on every state change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_r <= {TO_W{1'b0}};
    end else if (next_state_s != state_r) begin
      tmo_r <= {TO_W{1'b0}};
    end else if (waiting_s) begin
      tmo_r <= tmo_r + TO_W'(1);
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // Sticky bus-error flag, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus_err_r <= 1'b0;
    end else if (timeout_s) begin
      bus_err_r <= 1'b1;
    end else begin
      bus_err_r <= bus_err_r;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    next_state_s = S_F0;
    pc_inc_s     = 1'b0;
    pc_ld_s      = 1'b0;
    mar_sel_s    = 1'b0;
    mar_ld_s     = 1'b0;
    ir_ld_s      = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    acc_ld_s     = 1'b0;
    acc_clr_s    = 1'b0;
    alu_op_s     = ALU_PASS;
    illegal_s    = 1'b0;

    case (state_r)
      S_F0: begin
        mar_ld_s     = 1'b1;
        next_state_s = S_F1;
      end

      S_F1: begin
        mem_rd_s = 1'b1;
        if (bus.MEM_RDY) begin
          ir_ld_s      = 1'b1;
          pc_inc_s     = 1'b1;
          next_state_s = S_DEC;
        end else if (timeout_s) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_F1;
        end
      end

      S_DEC: begin
        if (!dec_ok_s) begin
          // The PC already moved past this word, so the bad opcode is skipped.
          illegal_s    = 1'b1;
          next_state_s = S_F0;
        end else if (mem_op_s) begin
          mar_sel_s    = 1'b1;
          mar_ld_s     = 1'b1;
          next_state_s = S_MEM;
        end else if (ex_op_s) begin
          next_state_s = S_EX;
        end else begin
          next_state_s = S_HALT;
        end
      end

      S_MEM: begin
        if (bus.STA) begin
          mem_wr_s = 1'b1;
        end else begin
          mem_rd_s = 1'b1;
        end
        if (bus.MEM_RDY) begin
          next_state_s = S_F0;
          if (bus.LDA) begin
            acc_ld_s = 1'b1;
            alu_op_s = ALU_PASS;
          end else if (bus.ADD) begin
            acc_ld_s = 1'b1;
            alu_op_s = ALU_ADD;
          end else if (bus.SUB) begin
            acc_ld_s = 1'b1;
            alu_op_s = ALU_SUB;
          end else if (bus.XOR) begin
            acc_ld_s = 1'b1;
            alu_op_s = ALU_XOR;
          end else begin
            acc_ld_s = 1'b0;
          end
        end else if (timeout_s) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_MEM;
        end
      end

      S_EX: begin
        next_state_s = S_F0;
        if (bus.INC) begin
          acc_ld_s = 1'b1;
          alu_op_s = ALU_INC;
        end else if (bus.CLR) begin
          acc_clr_s = 1'b1;
        end else if (bus.JMP) begin
          pc_ld_s = 1'b1;
        end else if (bus.JPZ) begin
          pc_ld_s = bus.Z;
        end else if (bus.JPN) begin
          pc_ld_s = bus.N;
        end else begin
          pc_ld_s = 1'b0;
        end
      end

      S_HALT: begin
        next_state_s = S_HALT;
      end

      default: begin
        next_state_s = S_F0;
      end
    endcase
  end

  // Reset masks every output immediately, including mid-access.
  assign bus.PC_INC  = pc_inc_s  & ~RST;
  assign bus.PC_LD   = pc_ld_s   & ~RST;
  assign bus.MAR_SEL = mar_sel_s & ~RST;
  assign bus.MAR_LD  = mar_ld_s  & ~RST;
  assign bus.IR_LD   = ir_ld_s   & ~RST;
  assign bus.MEM_RD  = mem_rd_s  & ~RST;
  assign bus.MEM_WR  = mem_wr_s  & ~RST;
  assign bus.ACC_LD  = acc_ld_s  & ~RST;
  assign bus.ACC_CLR = acc_clr_s & ~RST;
  assign bus.ALU_OP  = RST ? 3'b000 : alu_op_s;
  assign bus.ILLEGAL = illegal_s & ~RST;
  assign bus.HALTED  = (state_r == S_HALT) & ~RST;
  assign bus.BUS_ERR = bus_err_r;
  assign bus.STATE   = RST ? 3'b000 : state_r;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Randomised bench: an instruction-level model expands each opcode into its expected
// per-cycle output trace and MEM_RDY pattern, which is replayed against the sequencer.
module tb_cpu_control_sequencer;
  localparam int TO_CYC = 15;

  typedef logic [17:0] vec_t;
  typedef struct packed {
    logic [10:0] dec;
    logic        z;
    logic        n;
    logic        rdy;
  } stim_t;

  localparam vec_t B_PC_INC  = 18'h20000;
  localparam vec_t B_PC_LD   = 18'h10000;
  localparam vec_t B_MAR_SEL = 18'h08000;
  localparam vec_t B_MAR_LD  = 18'h04000;
  localparam vec_t B_IR_LD   = 18'h02000;
  localparam vec_t B_MEM_RD  = 18'h01000;
  localparam vec_t B_MEM_WR  = 18'h00800;
  localparam vec_t B_ACC_LD  = 18'h00400;
  localparam vec_t B_ACC_CLR = 18'h00200;
  localparam vec_t B_HALTED  = 18'h00020;
  localparam vec_t B_ILLEGAL = 18'h00010;
  localparam vec_t B_BUS_ERR = 18'h00008;

  // opcode indices: 0 LDA 1 STA 2 ADD 3 SUB 4 XOR 5 INC 6 CLR 7 JMP 8 JPZ 9 JPN 10 HLT
  localparam logic [10:0] OP_LDA = 11'h001;
  localparam logic [10:0] OP_STA = 11'h002;
  localparam logic [10:0] OP_ADD = 11'h004;
  localparam logic [10:0] OP_SUB = 11'h008;
  localparam logic [10:0] OP_JPZ = 11'h100;
  localparam logic [10:0] OP_JPN = 11'h200;
  localparam logic [10:0] OP_HLT = 11'h400;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  cpu_ctrl_if bus();

  cpu_control_sequencer #(.TO_CYC(TO_CYC), .TO_W(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int    n_cmp = 0;
  int    n_err = 0;
  stim_t stim_q[$];
  vec_t  exp_q[$];
  vec_t  obs_q[$];
  bit    m_be;
  bit    m_halted;

  function automatic vec_t obs_now();
    return {bus.PC_INC, bus.PC_LD, bus.MAR_SEL, bus.MAR_LD, bus.IR_LD, bus.MEM_RD,
            bus.MEM_WR, bus.ACC_LD, bus.ACC_CLR, bus.ALU_OP, bus.HALTED, bus.ILLEGAL,
            bus.BUS_ERR, bus.STATE};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive(input stim_t s);
    {bus.HLT, bus.JPN, bus.JPZ, bus.JMP, bus.CLR, bus.INC,
     bus.XOR, bus.SUB, bus.ADD, bus.STA, bus.LDA} = s.dec;
    bus.Z       = s.z;
    bus.N       = s.n;
    bus.MEM_RDY = s.rdy;
  endtask

  task automatic push(input logic [10:0] dec, input logic rdy, input vec_t v,
                      input logic z, input logic n);
    stim_t s;
    s.dec = dec; s.z = z; s.n = n; s.rdy = rdy;
    stim_q.push_back(s);
    exp_q.push_back(m_be ? (v | B_BUS_ERR) : v);
  endtask

  task automatic plan_clear();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // A memory access stalls `waits` cycles; it errors if the stall reaches TO_CYC cycles.
  task automatic plan_access(input logic [10:0] dec, input int waits, input vec_t base,
                             input vec_t done_extra, output bit ok);
    int stalls;
    stalls = (waits < TO_CYC) ? waits : TO_CYC;
    for (int i = 0; i < stalls; i++) push(dec, 1'b0, base, rb(), rb());
    if (waits >= TO_CYC) begin
      m_be = 1'b1;
      m_halted = 1'b1;
      ok = 1'b0;
    end else begin
      push(dec, 1'b1, base | done_extra, rb(), rb());
      ok = 1'b1;
    end
  endtask

  task automatic plan_idle(input int k);
    for (int i = 0; i < k; i++) push(11'($urandom), rb(), B_HALTED | vec_t'(5), rb(), rb());
  endtask

  task automatic plan_instr(input logic [10:0] dec, input int f1w, input int memw,
                            input logic z, input logic n);
    bit   ok;
    int   idx;
    vec_t extra;
    logic [2:0] alu_tbl [5];
    alu_tbl[0] = 3'd0; alu_tbl[1] = 3'd0; alu_tbl[2] = 3'd1; alu_tbl[3] = 3'd2; alu_tbl[4] = 3'd3;
    if (m_halted) begin
      plan_idle(1);
      return;
    end
    push(dec, rb(), B_MAR_LD, rb(), rb());
    plan_access(dec, f1w, B_MEM_RD | vec_t'(1), B_IR_LD | B_PC_INC, ok);
    if (!ok) return;
    if ($countones(dec) != 1) begin
      push(dec, rb(), B_ILLEGAL | vec_t'(2), rb(), rb());
      return;
    end
    idx = 0;
    for (int i = 0; i < 11; i++) if (dec[i]) idx = i;
    if (idx <= 4) begin
      push(dec, rb(), B_MAR_SEL | B_MAR_LD | vec_t'(2), rb(), rb());
      extra = (idx == 1) ? vec_t'(0) : (B_ACC_LD | (vec_t'(alu_tbl[idx]) << 6));
      plan_access(dec, memw, ((idx == 1) ? B_MEM_WR : B_MEM_RD) | vec_t'(3), extra, ok);
    end else if (idx <= 9) begin
      push(dec, rb(), vec_t'(2), rb(), rb());
      case (idx)
        5:       extra = B_ACC_LD | (vec_t'(4) << 6);
        6:       extra = B_ACC_CLR;
        7:       extra = B_PC_LD;
        8:       extra = z ? B_PC_LD : vec_t'(0);
        default: extra = n ? B_PC_LD : vec_t'(0);
      endcase
      push(dec, rb(), extra | vec_t'(4), z, n);
    end else begin
      push(dec, rb(), vec_t'(2), rb(), rb());
      m_halted = 1'b1;
    end
  endtask

  // Replays the planned stimulus from a posedge+1 alignment and captures outputs at negedge.
  task automatic run_plan(input int limit);
    obs_q.delete();
    for (int i = 0; i < stim_q.size() && i < limit; i++) begin
      drive(stim_q[i]);
      @(negedge CLK);
      obs_q.push_back(obs_now());
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    m_be = 1'b0;
    m_halted = 1'b0;
    plan_clear();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(stim_t'($urandom));
      @(negedge CLK);
      n_cmp++;
      if (obs_now() !== 18'h0) begin
        n_err++;
        $display("FAIL reset cyc %0d: got %h want %h", i, obs_now(), 18'h0);
      end
    end
    do_reset();
  endtask

  task automatic test_lda();
    plan_clear();
    plan_instr(OP_LDA, 0, 0, 1'b0, 1'b0);
    plan_instr(OP_LDA, 0, 0, 1'b0, 1'b0);
    run_plan(5);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL lda cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    run_plan(0);
    do_reset();
  endtask

  task automatic test_sta_wait();
    plan_clear();
    plan_instr(OP_STA, 0, 3, 1'b0, 1'b0);
    plan_instr(OP_ADD, 2, 1, 1'b0, 1'b0);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sta_wait cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_jumps();
    plan_clear();
    plan_instr(OP_JPZ, 0, 0, 1'b0, 1'b1);
    plan_instr(OP_JPZ, 0, 0, 1'b1, 1'b0);
    plan_instr(OP_JPN, 0, 0, 1'b0, 1'b1);
    plan_instr(OP_JPN, 1, 0, 1'b1, 1'b0);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL jumps cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    plan_clear();
    plan_instr(11'h000, 0, 0, 1'b0, 1'b0);
    plan_instr(OP_ADD | OP_SUB, 1, 0, 1'b0, 1'b0);
    plan_instr(OP_LDA | OP_HLT, 0, 0, 1'b0, 1'b0);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL illegal cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] dec;
    int k;
    int f1w;
    int memw;
    plan_clear();
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 11);
      if (k <= 9) begin
        dec = 11'd1 << k;
      end else if (k == 10) begin
        dec = 11'($urandom);
        if ($countones(dec) == 1) dec = 11'd0;
      end else begin
        dec = 11'd0;
      end
      f1w  = ($urandom_range(0, 7) == 0) ? TO_CYC - 1 : $urandom_range(0, 3);
      memw = ($urandom_range(0, 7) == 0) ? TO_CYC - 1 : $urandom_range(0, 3);
      plan_instr(dec, f1w, memw, rb(), rb());
    end
    run_plan(100000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    plan_instr(OP_ADD, 0, TO_CYC - 1, 1'b0, 1'b0);
    plan_instr(OP_STA, TO_CYC - 1, 0, 1'b0, 1'b0);
    plan_instr(OP_SUB, 0, TO_CYC, 1'b0, 1'b0);
    plan_idle(3);
    plan_instr(OP_LDA, 0, 0, 1'b0, 1'b0);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL timeout_mem cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
    plan_instr(OP_LDA, TO_CYC, 0, 1'b0, 1'b0);
    plan_idle(3);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL timeout_f1 cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({bus.BUS_ERR, bus.HALTED} !== 2'b00) begin
      n_err++;
      $display("FAIL timeout_rst: got %b want %b", {bus.BUS_ERR, bus.HALTED}, 2'b00);
    end
    do_reset();
  endtask

  task automatic test_halt();
    plan_clear();
    plan_instr(OP_HLT, 0, 0, 1'b0, 1'b0);
    plan_idle(20);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL halt cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    plan_clear();
    plan_instr(OP_ADD, 0, 6, 1'b0, 1'b0);
    run_plan(5);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL mid_mem_pre cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if (obs_now() !== 18'h0) begin
      n_err++;
      $display("FAIL mid_mem_rst: got %h want %h", obs_now(), 18'h0);
    end
    do_reset();
    plan_instr(OP_LDA, 0, 0, 1'b0, 1'b0);
    run_plan(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL mid_mem_restart cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    drive(stim_t'(0));
    @(posedge CLK);
    #1;
    test_reset();
    test_lda();
    test_sta_wait();
    test_jumps();
    test_illegal();
    test_random();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
